// File: rtl/mlp_seq_ctrl.sv
// Sequencer for the 7-4-10 digit-classifier MLP. Both layers share one multiply-accumulate;
// weights and biases are streamed from an external synchronous ROM, one word per cycle.
// Issue stage drives w_en/w_addr, read stage tags the returning ROM word, consume logic
// folds it into the accumulator one edge later.
module mlp_seq_ctrl #(
  parameter int unsigned N_IN  = 7,
  parameter int unsigned N_HID = 4,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned H_W   = 8,
  parameter int unsigned E_W   = 12,
  parameter int unsigned AW    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_IN-1:0]   in_bits,
  output logic              w_en,
  output logic [AW-1:0]     w_addr,
  input  logic signed [7:0] w_data,
  output logic              busy,
  output logic              done,
  output logic [3:0]        prediction
);

  localparam int unsigned IdxW        = 4;  // holds class index 0..N_OUT-1
  localparam int unsigned PosW        = 3;  // holds term position 0..N_IN
  localparam int unsigned HidIdxW     = $clog2(N_HID);
  localparam int unsigned HidBiasBase = N_HID * N_IN;
  localparam int unsigned OutWBase    = HidBiasBase + N_HID;
  localparam int unsigned OutBiasBase = OutWBase + N_OUT * N_HID;

  typedef enum logic [1:0] {StIdle, StHid, StOut, StFin} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [PosW-1:0]       pos_q, pos_d;
  logic [N_IN-1:0]       in_q, in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [3:0]            pred_q, pred_d;

  // Issue stage: what is on the ROM address bus this cycle.
  logic                  iss_vld_q, iss_vld_d;
  logic                  iss_out_q, iss_out_d;
  logic [IdxW-1:0]       iss_idx_q;
  logic [PosW-1:0]       iss_pos_q;
  logic [AW-1:0]         w_addr_q, w_addr_d;
  logic [AW-1:0]         issue_addr;

  // Read stage: tag of the word currently on w_data.
  logic                  rd_vld_q, rd_out_q;
  logic [IdxW-1:0]       rd_idx_q;
  logic [PosW-1:0]       rd_pos_q;

  logic signed [E_W-1:0] acc_q, acc_d;
  logic signed [H_W-1:0] h_q [N_HID];
  logic signed [H_W-1:0] h_d [N_HID];
  logic signed [E_W-1:0] max_q, max_d;
  logic [3:0]            best_q, best_d;

  logic signed [E_W-1:0] w_ext, bias_x10, hid_term, prod, sum_hid, sum_out;
  logic signed [H_W-1:0] h_sel;
  logic [PosW-1:0]       term_sel;
  logic                  beats_max, last_consume;

  // ROM address for the current (phase, neuron/class, position) of the issue walk.
  always_comb begin
    issue_addr = '0;
    if (state_q == StHid) begin
      if (pos_q == '0) issue_addr = AW'(HidBiasBase + 32'(idx_q));
      else             issue_addr = AW'(32'(idx_q) * N_IN + 32'(pos_q) - 1);
    end else if (state_q == StOut) begin
      if (pos_q == '0) issue_addr = AW'(OutBiasBase + 32'(idx_q));
      else             issue_addr = AW'(OutWBase + 32'(idx_q) * N_HID + 32'(pos_q) - 1);
    end
  end

  // Consume the returning ROM word: accumulate, store hidden values, track argmax.
  always_comb begin
    acc_d        = acc_q;
    h_d          = h_q;
    max_d        = max_q;
    best_d       = best_q;
    pred_d       = pred_q;
    last_consume = 1'b0;
    w_ext        = E_W'(w_data);
    bias_x10     = (w_ext <<< 3) + (w_ext <<< 1);
    term_sel     = rd_pos_q - 3'd1;
    hid_term     = in_q[term_sel] ? w_ext : '0;
    h_sel        = h_q[HidIdxW'(term_sel)];
    // Product of sign-extended operands, taken mod 2^E_W like the parallel datapath.
    prod         = w_ext * E_W'(h_sel);
    sum_hid      = acc_q + hid_term;
    sum_out      = acc_q + prod;
    beats_max    = (rd_idx_q == '0) || (sum_out > max_q);
    if (rd_vld_q) begin
      if (!rd_out_q) begin
        if (rd_pos_q == '0) begin
          acc_d = w_ext;
        end else begin
          acc_d = sum_hid;
          if (rd_pos_q == PosW'(N_IN)) h_d[HidIdxW'(rd_idx_q)] = sum_hid[H_W-1:0];
        end
      end else begin
        if (rd_pos_q == '0) begin
          acc_d = bias_x10;
        end else begin
          acc_d = sum_out;
          if (rd_pos_q == PosW'(N_HID)) begin
            if (beats_max) begin
              max_d  = sum_out;
              best_d = rd_idx_q;
            end
            if (rd_idx_q == IdxW'(N_OUT - 1)) begin
              last_consume = 1'b1;
              pred_d       = beats_max ? rd_idx_q : best_q;
            end
          end
        end
      end
    end
  end

  // Sequencer FSM: walk the ROM address space, then wait for the last word to land.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    in_d      = in_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    iss_vld_d = (state_q == StHid) || (state_q == StOut);
    iss_out_d = (state_q == StOut);
    w_addr_d  = iss_vld_d ? issue_addr : w_addr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StHid;
          idx_d   = '0;
          pos_d   = '0;
          in_d    = in_bits;
          busy_d  = 1'b1;
        end
      end
      StHid: begin
        if (pos_q == PosW'(N_IN)) begin
          pos_d = '0;
          if (idx_q == IdxW'(N_HID - 1)) begin
            idx_d   = '0;
            state_d = StOut;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      StOut: begin
        if (pos_q == PosW'(N_HID)) begin
          pos_d = '0;
          if (idx_q == IdxW'(N_OUT - 1)) begin
            idx_d   = '0;
            state_d = StFin;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      StFin: begin
        if (last_consume) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  // State, pipeline and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      pos_q     <= '0;
      in_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pred_q    <= '0;
      iss_vld_q <= 1'b0;
      iss_out_q <= 1'b0;
      iss_idx_q <= '0;
      iss_pos_q <= '0;
      w_addr_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_out_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_pos_q  <= '0;
      acc_q     <= '0;
      for (int n = 0; n < int'(N_HID); n++) h_q[n] <= '0;
      max_q     <= '0;
      best_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      in_q      <= in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pred_q    <= pred_d;
      iss_vld_q <= iss_vld_d;
      iss_out_q <= iss_out_d;
      iss_idx_q <= idx_q;
      iss_pos_q <= pos_q;
      w_addr_q  <= w_addr_d;
      rd_vld_q  <= iss_vld_q;
      rd_out_q  <= iss_out_q;
      rd_idx_q  <= iss_idx_q;
      rd_pos_q  <= iss_pos_q;
      acc_q     <= acc_d;
      h_q       <= h_d;
      max_q     <= max_d;
      best_q    <= best_d;
    end
  end

  assign w_en       = iss_vld_q;
  assign w_addr     = w_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign prediction = pred_q;

endmodule

// File: tb/tb_mlp_seq_ctrl.sv
// Self-checking bench for mlp_seq_ctrl: synchronous ROM model, scoreboard of expected
// predictions popped by a monitor on every done pulse, plus address-order checking.
module tb_mlp_seq_ctrl;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [6:0]        in_bits = '0;
  logic              w_en;
  logic [6:0]        w_addr;
  logic signed [7:0] w_data = '0;
  logic              busy;
  logic              done;
  logic [3:0]        prediction;

  logic signed [7:0] rom [128];
  logic [3:0]        sb_q [$];
  int                n_total = 0;
  int                n_pass = 0;
  int                rd_seq = 0;

  mlp_seq_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_bits    (in_bits),
    .w_en       (w_en),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .busy       (busy),
    .done       (done),
    .prediction (prediction)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: word valid the cycle after the address.
  always @(posedge clk) if (w_en) w_data <= rom[w_addr];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Expected address of the s-th read of a run.
  function automatic int exp_addr(input int s);
    int n, p, c;
    if (s < 32) begin
      n = s / 8; p = s % 8;
      return (p == 0) ? 28 + n : n * 7 + p - 1;
    end else if (s < 82) begin
      c = s - 32; n = c / 5; p = c % 5;
      return (p == 0) ? 72 + n : 32 + n * 4 + p - 1;
    end
    return -1;
  endfunction

  // Parallel reference: hidden sums wrap at 8 bits, scores at 12 bits, strict-greater argmax.
  function automatic logic [3:0] golden(input logic [6:0] x);
    logic signed [7:0]  h [4];
    logic signed [7:0]  a8;
    logic signed [11:0] e, mx;
    logic [3:0]         best;
    mx = '0; best = '0;
    for (int n = 0; n < 4; n++) begin
      a8 = rom[28 + n];
      for (int i = 0; i < 7; i++) if (x[i]) a8 = a8 + rom[n * 7 + i];
      h[n] = a8;
    end
    for (int k = 0; k < 10; k++) begin
      e = 12'(int'(rom[72 + k]) * 10);
      for (int j = 0; j < 4; j++) e = e + 12'(int'(rom[32 + k * 4 + j]) * int'(h[j]));
      if (k == 0 || e > mx) begin
        mx = e;
        best = 4'(k);
      end
    end
    return best;
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 128; a++) rom[a] = '0;
  endtask

  task automatic load_trained_rom();
    logic [31:0] seed;
    seed = 32'h0000_1234;
    clear_rom();
    for (int a = 0; a < 82; a++) begin
      seed = seed * 32'd1103515245 + 32'd12345;
      rom[a] = seed[23:16];
    end
  endtask

  // Monitor: pops the scoreboard on done, checks address order on every read.
  initial begin
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_seq = 0;
      end else begin
        if (w_en) begin
          check("w_addr_order", int'(w_addr), exp_addr(rd_seq));
          rd_seq++;
        end
        if (done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            exp = sb_q.pop_front();
            check("prediction", int'(prediction), int'(exp));
          end
          check("w_en_cycles", rd_seq, 82);
          rd_seq = 0;
        end
      end
    end
  end

  // One inference; optional start pulses at two busy cycles must be ignored.
  task automatic run(input logic [6:0] x, input logic [3:0] exp_pred, input int glitch_a,
                     input int glitch_b);
    int  lat, bcnt;
    bit  seen;
    @(negedge clk);
    start = 1'b1;
    in_bits = x;
    sb_q.push_back(exp_pred);
    @(posedge clk);
    #1;
    start = 1'b0;
    in_bits = ~x;
    lat = 0; bcnt = int'(busy); seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      start = (lat == glitch_a || lat == glitch_b);
      if (done) seen = 1'b1;
      else bcnt += int'(busy);
    end
    start = 1'b0;
    check("done_latency", lat, 84);
    check("busy_cycles", bcnt, 84);
  endtask

  initial begin
    logic [6:0] x;
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    logic [6:0] x6;
    clear_rom();

    // Reset state and quiet idle.
    repeat (3) @(negedge clk);
    check("rst_w_en", int'(w_en), 0);
    check("rst_w_addr", int'(w_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_prediction", int'(prediction), 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      cnt += int'(w_en) + int'(busy);
    end
    check("idle_no_activity", cnt, 0);

    // Only output bias of class 3 set: score 50 wins.
    clear_rom();
    rom[75] = 8'sd5;
    run(7'h55, 4'd3, -1, -1);

    // All-zero ROM: all ties, lowest index wins; done is a single-cycle pulse.
    clear_rom();
    run(7'h2A, 4'd0, -1, -1);
    @(posedge clk);
    #1;
    check("done_pulse_width", int'(done), 0);
    check("pred_held", int'(prediction), 0);

    // Hidden wrap: 7*100 = 700 -> -68 at 8 bits.
    for (int i = 0; i < 7; i++) rom[i] = 8'sd100;
    rom[36] = 8'sd1;
    run(7'h7F, 4'd0, -1, -1);
    rom[36] = -8'sd1;
    run(7'h7F, 4'd1, -1, -1);
    run(7'h00, 4'd0, -1, -1);

    // Hidden bias path: h2=3, weight (7,2)=2 -> e7=6.
    clear_rom();
    rom[30] = 8'sd3;
    rom[62] = 8'sd2;
    run(7'h11, 4'd7, -1, -1);

    // Negative class-0 bias: class 1 (score 0) beats -10, later ties keep 1.
    clear_rom();
    rom[72] = -8'sd1;
    run(7'h40, 4'd1, -1, -1);

    // Output score wrap: bias 127 -> 1270, + 127*127=16129 -> 17399 mod 4096 = 1015 (class 0);
    // class 5 bias 100 -> 1000 stays below 1015, so class 0 wins.
    clear_rom();
    rom[28] = 8'sd127;
    rom[32] = 8'sd127;
    rom[72] = 8'sd127;
    rom[77] = 8'sd100;
    run(7'h00, 4'd0, -1, -1);

    // Trained ROM, full input sweep against the parallel reference.
    load_trained_rom();
    for (int v = 0; v < 128; v++) run(7'(v), golden(7'(v)), -1, -1);

    // Reset mid-run at edge E40: abandon, no done.
    x6 = 7'h35;
    @(negedge clk);
    start = 1'b1;
    in_bits = x6;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_w_en", int'(w_en), 0);
    check("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(done) + int'(w_en);
    end
    check("abort_quiet", cnt, 0);

    // Clean run after abort, with start pulses while busy that must be ignored.
    run(x6, golden(x6), 20, 50);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(w_en) + int'(busy);
    end
    check("no_extra_run", cnt, 0);
    check("pred_hold_after_run", int'(prediction), int'(golden(x6)));
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
